// File: rtl/parity_frame_sched.sv
// parity_frame_sched
// Round-robin arbiter for two parallel-word sources in front of a shared
// serial zero/one parity tracker. The granted word is shifted out LSB-first.
// Running parities of zeros and ones are kept for every bit shifted out.
// At frame end the "odd zeros, even ones" verdict goes back to the served source.

module parity_frame_sched #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             ser_valid,
  output logic             ser_bit,
  output logic             zero_par,
  output logic             one_par,
  output logic             done,
  output logic             done_id,
  output logic             result
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             winner_s;
  logic             last_r;
  logic             served_r;
  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    count_r;
  logic             zero_par_r;
  logic             one_par_r;
  logic [1:0]       gnt_r;

  // Fold one serialized bit into the {zero, one} parity pair.
  function automatic logic [1:0] par_update(input logic zp, input logic op, input logic b);
    return {zp ^ ~b, op ^ b};
  endfunction

  // Round-robin pick: on contention the source not served last wins.
  always_comb begin
    winner_s = 1'b0;
    if (req == 2'b11) begin
      winner_s = ~last_r;
    end else if (req == 2'b10) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: IDLE -> SHIFT on any request, WIDTH bits, one REPORT cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req != 2'b00) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (count_r == CW'(WIDTH - 1)) begin
          state_s = ST_REPORT;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_REPORT: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Datapath: capture on the grant edge, shift and accumulate parity in SHIFT.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_r     <= 1'b1;
      served_r   <= 1'b0;
      shreg_r    <= '0;
      count_r    <= '0;
      zero_par_r <= 1'b0;
      one_par_r  <= 1'b0;
      gnt_r      <= 2'b00;
    end else begin
      gnt_r <= 2'b00;
      case (state_r)
        ST_IDLE: begin
          if (req != 2'b00) begin
            shreg_r    <= winner_s ? data1 : data0;
            zero_par_r <= 1'b0;
            one_par_r  <= 1'b0;
            count_r    <= '0;
            last_r     <= winner_s;
            served_r   <= winner_s;
            gnt_r      <= winner_s ? 2'b10 : 2'b01;
          end
        end
        ST_SHIFT: begin
          {zero_par_r, one_par_r} <= par_update(zero_par_r, one_par_r, shreg_r[0]);
          shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
          count_r <= count_r + CW'(1);
        end
        ST_REPORT: begin
          // Parities hold their final values until the next grant.
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode from registered state and registered datapath only.
  always_comb begin
    gnt       = gnt_r;
    zero_par  = zero_par_r;
    one_par   = one_par_r;
    busy      = 1'b0;
    ser_valid = 1'b0;
    ser_bit   = 1'b0;
    done      = 1'b0;
    done_id   = 1'b0;
    result    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_SHIFT: begin
        busy      = 1'b1;
        ser_valid = 1'b1;
        ser_bit   = shreg_r[0];
      end
      ST_REPORT: begin
        busy    = 1'b1;
        done    = 1'b1;
        done_id = served_r;
        result  = zero_par_r & ~one_par_r;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_parity_frame_sched.sv
// Testbench for parity_frame_sched: directed scenarios plus random traffic.
// All expectations come from a timeline model that tracks cycles since the
// last grant edge, together with the captured word.

module tb_parity_frame_sched;

  localparam int WIDTH = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [1:0]       gnt;
  logic             busy;
  logic             ser_valid;
  logic             ser_bit;
  logic             zero_par;
  logic             one_par;
  logic             done;
  logic             done_id;
  logic             result;

  parity_frame_sched #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .gnt       (gnt),
    .busy      (busy),
    .ser_valid (ser_valid),
    .ser_bit   (ser_bit),
    .zero_par  (zero_par),
    .one_par   (one_par),
    .done      (done),
    .done_id   (done_id),
    .result    (result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame timeline relative to the grant edge.
  bit               m_active = 1'b0;
  int               m_pos    = 0;
  bit               m_win    = 1'b0;
  bit               m_last   = 1'b1;
  int               m_nbits  = 0;
  logic [WIDTH-1:0] m_word   = '0;
  logic [1:0]       m_gnt    = 2'b00;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at time %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply the rules for one rising edge, using the inputs present at that edge.
  task automatic model_edge();
    if (reset) begin
      m_active = 1'b0;
      m_last   = 1'b1;
      m_nbits  = 0;
      m_pos    = 0;
    end else if (!m_active) begin
      if (req != 2'b00) begin
        m_win    = (req == 2'b11) ? ~m_last : req[1];
        m_word   = m_win ? data1 : data0;
        m_last   = m_win;
        m_pos    = 0;
        m_nbits  = 0;
        m_active = 1'b1;
      end
    end else begin
      m_pos++;
      m_nbits = (m_pos > WIDTH) ? WIDTH : m_pos;
      if (m_pos == WIDTH + 1) m_active = 1'b0;
    end
  endtask

  // Compare every output against the model for the current cycle.
  task automatic check_outputs();
    int   ones;
    logic e_sv, e_sb, e_zp, e_op, e_dn;
    ones = 0;
    for (int i = 0; i < m_nbits; i++) ones += int'(m_word[i]);
    e_op  = ones[0];
    e_zp  = 1'((m_nbits - ones) % 2);
    e_sv  = m_active && (m_pos < WIDTH);
    e_sb  = e_sv ? m_word[m_pos] : 1'b0;
    e_dn  = m_active && (m_pos == WIDTH);
    m_gnt = (m_active && m_pos == 0) ? (m_win ? 2'b10 : 2'b01) : 2'b00;
    check_val("gnt",       16'(gnt),       16'(m_gnt));
    check_val("busy",      16'(busy),      16'(m_active));
    check_val("ser_valid", 16'(ser_valid), 16'(e_sv));
    check_val("ser_bit",   16'(ser_bit),   16'(e_sb));
    check_val("zero_par",  16'(zero_par),  16'(e_zp));
    check_val("one_par",   16'(one_par),   16'(e_op));
    check_val("done",      16'(done),      16'(e_dn));
    check_val("done_id",   16'(done_id),   16'(e_dn ? m_win : 1'b0));
    check_val("result",    16'(result),    16'(e_dn ? (e_zp & ~e_op) : 1'b0));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_frame(input logic [1:0] r, input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
    req   = r;
    data0 = d0;
    data1 = d1;
    cycle();
    req = 2'b00;
    repeat (WIDTH + 1) cycle();
  endtask

  initial begin
    logic [WIDTH-1:0] bits;
    int               nv;
    int               nd;
    logic [3:0]       ids;
    reset = 1'b1;
    req   = 2'b00;
    data0 = '0;
    data1 = '0;
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Frame from source 0 with 0000011, collecting the serial stream.
    req   = 2'b01;
    data0 = 7'b0000011;
    bits  = '0;
    nv    = 0;
    cycle();
    req = 2'b00;
    if (ser_valid) begin bits[nv] = ser_bit; nv++; end
    repeat (WIDTH + 2) begin
      cycle();
      if (ser_valid && nv < WIDTH) begin bits[nv] = ser_bit; nv++; end
      if (done) check_val("t1_result", 16'(result), 16'd1);
    end
    check_val("t1_bits",   16'(bits), 16'h0003);
    check_val("t1_nvalid", 16'(nv),   16'd7);

    // Frame from source 1 with 0000001.
    run_frame(2'b10, 7'h55, 7'b0000001);
    cycle();

    // Both requests held from reset: alternating grants.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    req   = 2'b11;
    data0 = 7'h2a;
    data1 = 7'h19;
    nd    = 0;
    ids   = '0;
    repeat (40) begin
      cycle();
      if (done && nd < 4) begin ids[nd] = done_id; nd++; end
    end
    check_val("t3_done_ids", 16'(ids), 16'h000a);
    req = 2'b00;
    repeat (WIDTH + 2) cycle();

    // req[1] raised mid-frame of a source-0 frame: waits for IDLE.
    req   = 2'b01;
    data0 = 7'h4c;
    data1 = 7'h33;
    cycle();
    req = 2'b00;
    repeat (3) cycle();
    req = 2'b10;
    repeat (12) cycle();
    req = 2'b00;
    repeat (WIDTH + 2) cycle();

    // Reset on the 4th ser_valid cycle aborts the frame.
    req   = 2'b10;
    data1 = 7'h6d;
    cycle();
    req = 2'b00;
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    req   = 2'b11;
    cycle();
    check_val("t5_gnt_after_reset", 16'(gnt), 16'h0001);
    req = 2'b00;
    repeat (WIDTH + 2) cycle();

    // All-ones and all-zeros words.
    run_frame(2'b01, 7'b1111111, 7'h00);
    run_frame(2'b01, 7'b0000000, 7'h7f);

    // Random traffic honouring the hold-until-grant rule.
    repeat (2000) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 2; i++) begin
        if (req[i] && m_gnt[i]) begin
          req[i] = ($urandom_range(0, 3) == 0);
        end else if (!req[i]) begin
          req[i] = ($urandom_range(0, 3) == 0);
        end
      end
      data0 = WIDTH'($urandom);
      data1 = WIDTH'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
